// File: rtl/axis_arb_pkg.sv
// Shared types, default sizes and the round-robin pick used by the packet arbiter.
package axis_arb_pkg;

  localparam int NS_DEF        = 4;
  localparam int DW_DEF        = 16;
  localparam int MAX_BEATS_DEF = 2048;
  localparam int RR_MAX_NS     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } arb_state_t;

  // Requests above the previous winner take priority; otherwise wrap to the lowest request.
  function automatic int rr_next(input logic [RR_MAX_NS-1:0] req, input int last, input int ns);
    int   pick_hi;
    int   pick_lo;
    logic hit_hi;
    logic hit_lo;
    pick_hi = 0;
    pick_lo = 0;
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    for (int i = 0; i < RR_MAX_NS; i++) begin
      if (i < ns && req[i]) begin
        if (!hit_lo) begin
          pick_lo = i;
          hit_lo  = 1'b1;
        end
        if (i > last && !hit_hi) begin
          pick_hi = i;
          hit_hi  = 1'b1;
        end
      end
    end
    return hit_hi ? pick_hi : pick_lo;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer: head entry drives the outputs, a spare
// entry absorbs the beat already in flight when the consumer stalls.
module axis_skid_buf #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         push;
  logic         pop;
  logic [W-1:0] spare;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Head entry and flags; in_ready falls only when head and spare are both occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!out_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        2'b01: begin
          if (!in_ready) begin
            out_data <= spare;
            in_ready <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b11: out_data <= in_data;
        default: ;
      endcase
    end
  end

  // Spare entry captures a beat arriving while the head is held; data only.
  always_ff @(posedge clk) begin
    if (push && out_valid && !pop) spare <= in_data;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream FIFO input.
// Grant is held until tlast; oversize packets are truncated and their tail dropped.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NS        = NS_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int IDW       = $clog2(NS)
) (
  input  logic [NS*DW-1:0] s_tdata,
  input  logic             clk,
  input  logic             rst,
  input  logic [NS-1:0]    s_tvalid,
  input  logic [NS-1:0]    s_tlast,
  output logic [NS-1:0]    s_tready,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  output logic [IDW-1:0]   m_tid,
  input  logic             m_tready,
  output logic             err_oversize
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int W  = DW + 1 + IDW;

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [IDW-1:0]       grant;
  logic [IDW-1:0]       last_grant;
  logic [CW-1:0]        cnt;
  logic [DW-1:0]        g_data;
  logic                 g_valid;
  logic                 g_last;
  logic                 g_ready;
  logic                 acc;
  logic                 at_limit;
  logic                 trunc;
  logic                 sb_in_valid;
  logic                 sb_in_ready;
  logic [W-1:0]         sb_in;
  logic [W-1:0]         sb_out;
  logic [RR_MAX_NS-1:0] req_ext;

  assign req_ext  = {{(RR_MAX_NS-NS){1'b0}}, s_tvalid};
  assign g_data   = s_tdata[int'(grant)*DW +: DW];
  assign g_valid  = s_tvalid[grant];
  assign g_last   = s_tlast[grant];
  assign g_ready  = (state == PKT) ? sb_in_ready : (state == DROP);
  assign acc      = g_valid & g_ready;
  assign at_limit = (cnt == CW'(MAX_BEATS - 1));
  assign trunc    = (state == PKT) & acc & ~g_last & at_limit;
  // A beat reaching the length limit is closed with a forced tlast.
  assign sb_in    = {g_data, g_last | at_limit, grant};

  // State register plus the registered oversize pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_nxt;
      err_oversize <= trunc;
    end
  end

  // Grant selection, round-robin history and per-packet beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= IDW'(NS - 1);
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (|s_tvalid) grant <= IDW'(rr_next(req_ext, int'(last_grant), NS));
        PKT: begin
          if (acc) begin
            if (g_last) begin
              last_grant <= grant;
              cnt        <= '0;
            end else if (at_limit) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DROP: if (acc && g_last) last_grant <= grant;
        default: ;
      endcase
    end
  end

  // Next-state decision: arbitrate, forward a packet, or discard an oversize tail.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|s_tvalid) state_nxt = PKT;
      PKT: begin
        if (acc) begin
          if (g_last)        state_nxt = IDLE;
          else if (at_limit) state_nxt = DROP;
        end
      end
      DROP: if (acc && g_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready goes only to the granted source; in DROP its beats are swallowed.
  always_comb begin
    s_tready    = '0;
    sb_in_valid = 1'b0;
    case (state)
      PKT: begin
        s_tready[grant] = sb_in_ready;
        sb_in_valid     = g_valid;
      end
      DROP: s_tready[grant] = 1'b1;
      default: ;
    endcase
  end

  axis_skid_buf #(
    .W(W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (sb_in),
    .in_valid (sb_in_valid),
    .in_ready (sb_in_ready),
    .out_data (sb_out),
    .out_valid(m_tvalid),
    .out_ready(m_tready)
  );

  assign {m_tdata, m_tlast, m_tid} = sb_out;

endmodule
